// File: rtl/mdu_iter_if.sv
// mdu_iter_if: issue and writeback channels of the iterative multiply/divide unit.
//   issue_valid/issue_ready  request handshake from the reservation station
//   issue_op/tag/rd          funct3, ROB id, destination register
//   issue_op1/op2            rs1/rs2 values
//   out_valid/out_ready      writeback handshake
//   out_tag/out_rd/result    tagged result
// master: issuer/writeback side; slave: the unit.
interface mdu_iter_if #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned TAGW = 7,
   parameter int unsigned RDW  = 6
);
   logic            issue_valid;
   logic            issue_ready;
   logic [2:0]      issue_op;
   logic [TAGW-1:0] issue_tag;
   logic [RDW-1:0]  issue_rd;
   logic [XLEN-1:0] issue_op1;
   logic [XLEN-1:0] issue_op2;
   logic            out_valid;
   logic            out_ready;
   logic [TAGW-1:0] out_tag;
   logic [RDW-1:0]  out_rd;
   logic [XLEN-1:0] out_result;

   modport master (
      output issue_valid, issue_op, issue_tag, issue_rd, issue_op1, issue_op2, out_ready,
      input  issue_ready, out_valid, out_tag, out_rd, out_result
   );

   modport slave (
      input  issue_valid, issue_op, issue_tag, issue_rd, issue_op1, issue_op2, out_ready,
      output issue_ready, out_valid, out_tag, out_rd, out_result
   );
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit.
//   clk    clock
//   rst    synchronous reset, active-high
//   flush  ROB flush; aborts any in-flight op or pending result
//   bus    mdu_iter_if slave: issue channel in, tagged result channel out
// Multiply is shift-add on operand magnitudes, MUL_UNROLL multiplier bits per cycle.
// Divide is restoring division on magnitudes, DIV_UNROLL quotient bits per cycle.
// The first BUSY cycle converts operands to magnitudes and resolves div-by-zero and
// signed overflow, which go straight to DONE.
module mdu_iter #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned TAGW       = 7,
   parameter int unsigned RDW        = 6,
   parameter int unsigned MUL_UNROLL = 2,
   parameter int unsigned DIV_UNROLL = 1
) (
   input logic       clk,
   input logic       rst,
   input logic       flush,
   mdu_iter_if.slave bus
);
   localparam int unsigned      CntW   = $clog2(XLEN + 1);
   localparam logic [CntW-1:0]  MulN   = CntW'(XLEN / MUL_UNROLL);
   localparam logic [CntW-1:0]  DivN   = CntW'(XLEN / DIV_UNROLL);
   localparam logic [XLEN-1:0]  MinVal = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [2:0]       OpMul    = 3'd0;
   localparam logic [2:0]       OpMulh   = 3'd1;
   localparam logic [2:0]       OpMulhsu = 3'd2;

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic [TAGW-1:0]   tag_q, tag_d;
   logic [RDW-1:0]    rd_q, rd_d;
   logic [XLEN-1:0]   a_q, a_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic              neg_q, neg_d;
   logic              first_q, first_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [TAGW-1:0]   out_tag_q, out_tag_d;
   logic [RDW-1:0]    out_rd_q, out_rd_d;
   logic [XLEN-1:0]   out_res_q, out_res_d;

   logic accept;

   assign bus.issue_ready = (state_q == StIdle) | ((state_q == StDone) & bus.out_ready);
   assign accept          = bus.issue_valid & bus.issue_ready;
   assign bus.out_valid   = (state_q == StDone);
   assign bus.out_tag     = out_tag_q;
   assign bus.out_rd      = out_rd_q;
   assign bus.out_result  = out_res_q;

   // Operand signs, magnitudes and special cases; a_q/b_q hold raw operands in the
   // first BUSY cycle, which is the only cycle these are consumed.
   logic            is_div, sign_a, sign_b, div_zero, div_ovf;
   logic [XLEN-1:0] mag_a, mag_b, special_res;

   always_comb begin
      is_div = op_q[2];
      if (is_div) begin
         sign_a = ~op_q[0] & a_q[XLEN-1];
         sign_b = ~op_q[0] & b_q[XLEN-1];
      end else begin
         sign_a = ((op_q == OpMulh) | (op_q == OpMulhsu)) & a_q[XLEN-1];
         sign_b = (op_q == OpMulh) & b_q[XLEN-1];
      end
      mag_a    = sign_a ? -a_q : a_q;
      mag_b    = sign_b ? -b_q : b_q;
      div_zero = is_div & (b_q == '0);
      div_ovf  = is_div & ~op_q[0] & (a_q == MinVal) & (b_q == '1);
      if (div_zero) begin
         special_res = op_q[1] ? a_q : '1;
      end else begin
         special_res = op_q[1] ? '0 : MinVal;
      end
   end

   // One iteration of each datapath. acc_q = {hi, lo}: multiply keeps the partial
   // product in hi and the remaining multiplier in lo; divide keeps the partial
   // remainder in hi and the dividend/quotient shift register in lo.
   logic [2*XLEN-1:0] mul_p, div_p, mul_full;
   logic [XLEN:0]     mul_sum, div_r, div_diff;
   logic [XLEN-1:0]   div_val, final_res;

   always_comb begin
      mul_p   = acc_q;
      mul_sum = '0;
      for (int k = 0; k < MUL_UNROLL; k++) begin
         mul_sum = {1'b0, mul_p[2*XLEN-1:XLEN]} + (mul_p[0] ? {1'b0, b_q} : '0);
         mul_p   = {mul_sum, mul_p[XLEN-1:1]};
      end

      div_p    = acc_q;
      div_r    = '0;
      div_diff = '0;
      for (int k = 0; k < DIV_UNROLL; k++) begin
         div_r    = {div_p[2*XLEN-1:XLEN], div_p[XLEN-1]};
         div_diff = div_r - {1'b0, b_q};
         // Remainder stays below the divisor, so the top bit is a clean borrow.
         if (!div_diff[XLEN]) begin
            div_p = {div_diff[XLEN-1:0], div_p[XLEN-2:0], 1'b1};
         end else begin
            div_p = {div_r[XLEN-1:0], div_p[XLEN-2:0], 1'b0};
         end
      end

      mul_full = neg_q ? -mul_p : mul_p;
      div_val  = op_q[1] ? div_p[2*XLEN-1:XLEN] : div_p[XLEN-1:0];
      if (!is_div) begin
         final_res = (op_q == OpMul) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
      end else begin
         final_res = neg_q ? -div_val : div_val;
      end
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      tag_d     = tag_q;
      rd_d      = rd_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      neg_d     = neg_q;
      first_d   = first_q;
      cnt_d     = cnt_q;
      out_tag_d = out_tag_q;
      out_rd_d  = out_rd_q;
      out_res_d = out_res_q;

      case (state_q)
         StIdle: state_d = StIdle;
         StBusy: begin
            if (first_q) begin
               first_d = 1'b0;
               if (div_zero | div_ovf) begin
                  state_d   = StDone;
                  out_res_d = special_res;
                  out_tag_d = tag_q;
                  out_rd_d  = rd_q;
               end else if (is_div) begin
                  acc_d = {{XLEN{1'b0}}, mag_a};
                  b_d   = mag_b;
                  // Remainder follows the dividend sign, quotient the sign product.
                  neg_d = op_q[1] ? sign_a : (sign_a ^ sign_b);
               end else begin
                  acc_d = {{XLEN{1'b0}}, mag_b};
                  b_d   = mag_a;
                  neg_d = sign_a ^ sign_b;
               end
            end else begin
               cnt_d = cnt_q - CntW'(1);
               acc_d = is_div ? div_p : mul_p;
               if (cnt_q == CntW'(1)) begin
                  state_d   = StDone;
                  out_res_d = final_res;
                  out_tag_d = tag_q;
                  out_rd_d  = rd_q;
               end
            end
         end
         StDone: begin
            if (bus.out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // Accept is only possible from IDLE or a retiring DONE.
      if (accept) begin
         state_d = StBusy;
         op_d    = bus.issue_op;
         tag_d   = bus.issue_tag;
         rd_d    = bus.issue_rd;
         a_d     = bus.issue_op1;
         b_d     = bus.issue_op2;
         first_d = 1'b1;
         cnt_d   = bus.issue_op[2] ? DivN : MulN;
      end

      if (flush) begin
         state_d = StIdle;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         op_q      <= '0;
         tag_q     <= '0;
         rd_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         neg_q     <= 1'b0;
         first_q   <= 1'b0;
         cnt_q     <= '0;
         out_tag_q <= '0;
         out_rd_q  <= '0;
         out_res_q <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         tag_q     <= tag_d;
         rd_q      <= rd_d;
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         neg_q     <= neg_d;
         first_q   <= first_d;
         cnt_q     <= cnt_d;
         out_tag_q <= out_tag_d;
         out_rd_q  <= out_rd_d;
         out_res_q <= out_res_d;
      end
   end
endmodule
